// File: rtl/mips_pkg.sv
// Shared constants for the MIPS-style datapath: widths and ALU control codes.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int IMM_W      = 16;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source register value through EX, MEM and WB forwarding; r0 always reads 0.
module operand_fwd_mux #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic [RA-1:0] src_addr,
  input  logic [W-1:0]  rf_data,
  input  logic          ex_en,
  input  logic [RA-1:0] ex_addr,
  input  logic [W-1:0]  ex_data,
  input  logic          mem_en,
  input  logic [RA-1:0] mem_addr,
  input  logic [W-1:0]  mem_data,
  input  logic          wb_en,
  input  logic [RA-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  output logic [W-1:0]  fwd_data
);

  // Youngest producer wins; earlier branches shadow older stages.
  always_comb begin
    fwd_data = rf_data;
    if (src_addr == '0)
      fwd_data = '0;
    else if (ex_en && ex_addr == src_addr)
      fwd_data = ex_data;
    else if (mem_en && mem_addr == src_addr)
      fwd_data = mem_data;
    else if (wb_en && wb_addr == src_addr)
      fwd_data = wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register in front of the ALU: operand forwarding, immediate extension,
// load-use stall and bubble insertion.
module alu_operand_stage
  import mips_pkg::*;
#(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RA-1:0] rs_addr,
  input  logic [RA-1:0] rt_addr,
  input  logic [W-1:0]  rs_data,
  input  logic [W-1:0]  rt_data,
  input  logic [15:0]   imm16,
  input  logic          alu_src,
  input  logic          imm_zext,
  input  logic [3:0]    alu_ctrl_in,
  input  logic [RA-1:0] dest_in,
  input  logic          reg_write_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic [W-1:0]  ex_result,
  input  logic          mem_fwd_en,
  input  logic [RA-1:0] mem_fwd_addr,
  input  logic [W-1:0]  mem_fwd_data,
  input  logic          wb_fwd_en,
  input  logic [RA-1:0] wb_fwd_addr,
  input  logic [W-1:0]  wb_fwd_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic [3:0]    alu_ctrl,
  output logic [W-1:0]  store_data,
  output logic [RA-1:0] dest,
  output logic          reg_write,
  output logic          mem_read,
  output logic          mem_write
);

  function automatic logic [W-1:0] ext_imm(input logic [15:0] imm, input logic zext);
    return zext ? {{(W-16){1'b0}}, imm} : {{(W-16){imm[15]}}, imm};
  endfunction

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [W-1:0]  store_data_q, store_data_d;
  logic [RA-1:0] dest_q, dest_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          adv, hz, ex_fwd_en;
  logic [W-1:0]  rs_fwd, rt_fwd;

  assign adv       = !out_valid_q || out_ready;
  // A store's rt is read as data, so it depends on the load even with alu_src set.
  assign hz        = in_valid && out_valid_q && mem_read_q && (dest_q != '0) &&
                     ((dest_q == rs_addr) ||
                      ((dest_q == rt_addr) && (!alu_src || mem_write_in)));
  assign in_ready  = adv && !hz && !flush;
  assign ex_fwd_en = out_valid_q && reg_write_q && !mem_read_q;

  operand_fwd_mux #(.W(W), .RA(RA)) u_fwd_rs (
    .src_addr (rs_addr),      .rf_data  (rs_data),
    .ex_en    (ex_fwd_en),    .ex_addr  (dest_q),       .ex_data  (ex_result),
    .mem_en   (mem_fwd_en),   .mem_addr (mem_fwd_addr), .mem_data (mem_fwd_data),
    .wb_en    (wb_fwd_en),    .wb_addr  (wb_fwd_addr),  .wb_data  (wb_fwd_data),
    .fwd_data (rs_fwd)
  );

  operand_fwd_mux #(.W(W), .RA(RA)) u_fwd_rt (
    .src_addr (rt_addr),      .rf_data  (rt_data),
    .ex_en    (ex_fwd_en),    .ex_addr  (dest_q),       .ex_data  (ex_result),
    .mem_en   (mem_fwd_en),   .mem_addr (mem_fwd_addr), .mem_data (mem_fwd_data),
    .wb_en    (wb_fwd_en),    .wb_addr  (wb_fwd_addr),  .wb_data  (wb_fwd_data),
    .fwd_data (rt_fwd)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    store_data_d = store_data_q;
    dest_d       = dest_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    if (flush) begin
      out_valid_d = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (adv && in_valid && !hz) begin
      out_valid_d  = 1'b1;
      op_a_d       = rs_fwd;
      op_b_d       = alu_src ? ext_imm(imm16, imm_zext) : rt_fwd;
      alu_ctrl_d   = alu_ctrl_in;
      store_data_d = rt_fwd;
      dest_d       = dest_in;
      reg_write_d  = reg_write_in;
      mem_read_d   = mem_read_in;
      mem_write_d  = mem_write_in;
    end else if (adv) begin
      out_valid_d = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      alu_ctrl_q   <= '0;
      store_data_q <= '0;
      dest_q       <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      store_data_q <= store_data_d;
      dest_q       <= dest_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign store_data = store_data_q;
  assign dest       = dest_q;
  assign reg_write  = reg_write_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus a randomized run against a reference model.
module tb_alu_operand_stage;
  import mips_pkg::*;

  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready;
  logic [RA-1:0] rs_addr, rt_addr, dest_in, dest;
  logic [W-1:0]  rs_data, rt_data, ex_result, mem_fwd_data, wb_fwd_data;
  logic [15:0]   imm16;
  logic          alu_src, imm_zext, reg_write_in, mem_read_in, mem_write_in;
  logic [3:0]    alu_ctrl_in, alu_ctrl;
  logic          mem_fwd_en, wb_fwd_en, flush, out_valid, out_ready;
  logic [RA-1:0] mem_fwd_addr, wb_fwd_addr;
  logic [W-1:0]  op_a, op_b, store_data;
  logic          reg_write, mem_read, mem_write;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.W(W), .RA(RA)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .alu_src(alu_src), .imm_zext(imm_zext), .alu_ctrl_in(alu_ctrl_in),
    .dest_in(dest_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .ex_result(ex_result),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .alu_ctrl(alu_ctrl), .store_data(store_data),
    .dest(dest), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write)
  );

  typedef struct packed {
    logic          v;
    logic [W-1:0]  a, b;
    logic [3:0]    c;
    logic [W-1:0]  sd;
    logic [RA-1:0] d;
    logic          rw, mr, mw;
  } st_t;

  task automatic idle();
    in_valid = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0; imm16 = 0;
    alu_src = 0; imm_zext = 0; alu_ctrl_in = 0; dest_in = 0; reg_write_in = 0;
    mem_read_in = 0; mem_write_in = 0; ex_result = 0; mem_fwd_en = 0; mem_fwd_addr = 0;
    mem_fwd_data = 0; wb_fwd_en = 0; wb_fwd_addr = 0; wb_fwd_data = 0; flush = 0;
    out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); tick(); reset = 0; #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vectors++; if (op_a !== '0 || op_b !== '0 || store_data !== '0) begin miscompares++; $display("FAIL reset_data got %h %h %h want 0", op_a, op_b, store_data); end
    vectors++; if ({reg_write, mem_read, mem_write} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl got %b want 000", {reg_write, mem_read, mem_write}); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    idle(); in_valid = 1; rs_addr = 1; rt_addr = 2; rs_data = 5; rt_data = 3;
    alu_ctrl_in = ALU_SUB; dest_in = 3; reg_write_in = 1;
    tick();
    vectors++; if (op_a !== 32'd5 || op_b !== 32'd3) begin miscompares++; $display("FAIL basic_ops got %0d %0d want 5 3", op_a, op_b); end
    vectors++; if (alu_ctrl !== 4'd6 || out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_ctrl got %0d v%0b want 6 v1", alu_ctrl, out_valid); end
    vectors++; if (store_data !== 32'd3 || dest !== 5'd3 || reg_write !== 1'b1) begin miscompares++; $display("FAIL basic_misc got %0d %0d %0b want 3 3 1", store_data, dest, reg_write); end
    idle(); tick();
    vectors++; if (out_valid !== 1'b0 || reg_write !== 1'b0) begin miscompares++; $display("FAIL basic_bubble got v%0b rw%0b want 0 0", out_valid, reg_write); end
  endtask

  task automatic test_ext();
    idle(); in_valid = 1; alu_src = 1; imm16 = 16'hFFFE; imm_zext = 0; rt_addr = 4; rt_data = 9;
    tick();
    vectors++; if (op_b !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL sext got %h want fffffffe", op_b); end
    vectors++; if (store_data !== 32'd9) begin miscompares++; $display("FAIL sext_store got %0d want 9", store_data); end
    imm_zext = 1; tick();
    vectors++; if (op_b !== 32'h0000FFFE) begin miscompares++; $display("FAIL zext got %h want 0000fffe", op_b); end
  endtask

  task automatic test_fwd_priority();
    idle(); in_valid = 1; alu_ctrl_in = ALU_ADD; dest_in = 8; reg_write_in = 1; tick();
    ex_result = 42; rs_addr = 8; rs_data = 11;
    mem_fwd_en = 1; mem_fwd_addr = 8; mem_fwd_data = 55;
    wb_fwd_en = 1; wb_fwd_addr = 8; wb_fwd_data = 66;
    rt_addr = 8; rt_data = 12; dest_in = 8;
    tick();
    vectors++; if (op_a !== 32'd42) begin miscompares++; $display("FAIL fwd_ex_rs got %0d want 42", op_a); end
    vectors++; if (op_b !== 32'd42) begin miscompares++; $display("FAIL fwd_ex_rt got %0d want 42", op_b); end
    rs_addr = 0; rs_data = 123; mem_fwd_addr = 0; wb_fwd_addr = 0; dest_in = 0; tick();
    vectors++; if (op_a !== 32'd0) begin miscompares++; $display("FAIL fwd_r0 got %0d want 0", op_a); end
    dest_in = 2; tick();
    rs_addr = 5; rs_data = 1; mem_fwd_addr = 5; wb_fwd_addr = 5; rt_addr = 6; rt_data = 2;
    wb_fwd_addr = 6; tick();
    vectors++; if (op_a !== 32'd55 || op_b !== 32'd66) begin miscompares++; $display("FAIL fwd_mem_wb got %0d %0d want 55 66", op_a, op_b); end
  endtask

  task automatic test_load_use();
    idle(); in_valid = 1; rs_addr = 1; rs_data = 100; alu_src = 1; imm16 = 4;
    alu_ctrl_in = ALU_ADD; dest_in = 9; reg_write_in = 1; mem_read_in = 1; tick();
    idle(); in_valid = 1; rs_addr = 1; rs_data = 1; rt_addr = 9; rt_data = 0;
    alu_ctrl_in = ALU_OR; dest_in = 10; reg_write_in = 1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall got %0b want 0", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0 || {reg_write, mem_read, mem_write} !== 3'b000) begin miscompares++; $display("FAIL lu_bubble got v%0b %b want 0 000", out_valid, {reg_write, mem_read, mem_write}); end
    mem_fwd_en = 1; mem_fwd_addr = 9; mem_fwd_data = 77; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lu_release got %0b want 1", in_ready); end
    tick();
    vectors++; if (op_b !== 32'd77 || out_valid !== 1'b1 || alu_ctrl !== ALU_OR) begin miscompares++; $display("FAIL lu_capture got %0d v%0b c%0d want 77 v1 c1", op_b, out_valid, alu_ctrl); end
  endtask

  task automatic test_backpressure();
    idle(); in_valid = 1; rs_addr = 1; rs_data = 10; rt_addr = 2; rt_data = 20;
    alu_ctrl_in = ALU_ADD; dest_in = 4; reg_write_in = 1; tick();
    rs_data = 30; rt_data = 40; alu_ctrl_in = ALU_OR; dest_in = 5; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
      tick();
      vectors++; if (op_a !== 32'd10 || op_b !== 32'd20 || alu_ctrl !== ALU_ADD || out_valid !== 1'b1 || dest !== 5'd4) begin
        miscompares++; $display("FAIL bp_hold[%0d] got %0d %0d %0d v%0b d%0d want 10 20 2 v1 d4", i, op_a, op_b, alu_ctrl, out_valid, dest); end
    end
    out_ready = 1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release got %0b want 1", in_ready); end
    tick();
    vectors++; if (op_a !== 32'd30 || op_b !== 32'd40 || alu_ctrl !== ALU_OR || dest !== 5'd5) begin miscompares++; $display("FAIL bp_accept got %0d %0d %0d %0d want 30 40 1 5", op_a, op_b, alu_ctrl, dest); end
  endtask

  task automatic test_flush();
    idle(); in_valid = 1; rs_addr = 1; rs_data = 100; alu_src = 1; imm16 = 4;
    dest_in = 9; reg_write_in = 1; mem_read_in = 1; tick();
    idle(); in_valid = 1; rt_addr = 9; dest_in = 10; reg_write_in = 1; mem_write_in = 1;
    out_ready = 0; flush = 1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0 || {reg_write, mem_read, mem_write} !== 3'b000) begin miscompares++; $display("FAIL flush_ctrl got v%0b %b want 0 000", out_valid, {reg_write, mem_read, mem_write}); end
    vectors++; if (op_a !== 32'd100) begin miscompares++; $display("FAIL flush_data_hold got %0d want 100", op_a); end
  endtask

  task automatic test_reset_mid_stall();
    idle(); in_valid = 1; rs_addr = 1; rs_data = 100; dest_in = 9; reg_write_in = 1; mem_read_in = 1; tick();
    idle(); in_valid = 1; rs_addr = 9; reset = 1; tick(); reset = 0; in_valid = 0; #1;
    vectors++; if (out_valid !== 1'b0 || op_a !== '0 || mem_read !== 1'b0 || dest !== '0) begin miscompares++; $display("FAIL rst_stall got v%0b a%0d mr%0b d%0d want 0 0 0 0", out_valid, op_a, mem_read, dest); end
  endtask

  task automatic test_random();
    st_t m, nx, got;
    logic [W-1:0] fa, fb;
    logic e_adv, e_hz, e_rdy;
    idle(); reset = 1; tick(); reset = 0;
    m = '0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) < 2); flush = ($urandom_range(0, 99) < 6);
      in_valid = $urandom_range(0, 3) != 0; out_ready = $urandom_range(0, 3) != 0;
      rs_addr = $urandom_range(0, 3); rt_addr = $urandom_range(0, 3); dest_in = $urandom_range(0, 3);
      rs_data = $urandom; rt_data = $urandom; imm16 = $urandom; ex_result = $urandom;
      alu_src = $urandom; imm_zext = $urandom; alu_ctrl_in = $urandom;
      reg_write_in = $urandom; mem_read_in = $urandom; mem_write_in = $urandom;
      mem_fwd_en = $urandom; mem_fwd_addr = $urandom_range(0, 3); mem_fwd_data = $urandom;
      wb_fwd_en = $urandom; wb_fwd_addr = $urandom_range(0, 3); wb_fwd_data = $urandom;
      // Reference: pick the youngest matching producer for each source.
      fa = rs_data; fb = rt_data;
      if (wb_fwd_en && wb_fwd_addr == rs_addr) fa = wb_fwd_data;
      if (mem_fwd_en && mem_fwd_addr == rs_addr) fa = mem_fwd_data;
      if (m.v && m.rw && !m.mr && m.d == rs_addr) fa = ex_result;
      if (rs_addr == 0) fa = 0;
      if (wb_fwd_en && wb_fwd_addr == rt_addr) fb = wb_fwd_data;
      if (mem_fwd_en && mem_fwd_addr == rt_addr) fb = mem_fwd_data;
      if (m.v && m.rw && !m.mr && m.d == rt_addr) fb = ex_result;
      if (rt_addr == 0) fb = 0;
      e_adv = !m.v || out_ready;
      e_hz  = in_valid && m.v && m.mr && m.d != 0 &&
              (m.d == rs_addr || (m.d == rt_addr && (!alu_src || mem_write_in)));
      e_rdy = e_adv && !e_hz && !flush;
      #1;
      vectors++; if (in_ready !== e_rdy) begin miscompares++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", n, in_ready, e_rdy); end
      nx = m;
      if (reset) nx = '0;
      else if (flush) begin nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0; end
      else if (e_adv && in_valid && !e_hz) begin
        nx.v = 1; nx.a = fa; nx.sd = fb; nx.c = alu_ctrl_in; nx.d = dest_in;
        nx.b = !alu_src ? fb : (imm_zext ? W'(imm16) : W'(int'($signed(imm16))));
        nx.rw = reg_write_in; nx.mr = mem_read_in; nx.mw = mem_write_in;
      end else if (e_adv) begin nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0; end
      tick();
      m = nx;
      got = {out_valid, op_a, op_b, alu_ctrl, store_data, dest, reg_write, mem_read, mem_write};
      vectors++; if (got !== m) begin miscompares++; $display("FAIL rnd_state[%0d] got %h want %h", n, got, m); end
    end
    idle();
  endtask

  initial begin
    idle(); reset = 1;
    test_reset();
    test_basic();
    test_ext();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage directly upstream of the ALU. It captures a decoded instruction, resolves both operands through forwarding, the immediate path and sign/zero extension, and holds the ALU's operand/control inputs stable for one EX cycle. It also detects load-use hazards against the instruction it currently holds, stalls decode, and inserts bubbles. The ALU consumes `op_a`, `op_b` and `alu_ctrl` combinationally from this block's registers.

## Interface
Parameters:
- `W`, 32: datapath width.
- `RA`, 5: register address width.

Ports:
- `clk`  in  1: clock; every state change occurs on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: decode presents an instruction.
- `in_ready`  out  1: stage accepts this cycle (combinational).
- `rs_addr`, `rt_addr`  in  RA: source register indices.
- `rs_data`, `rt_data`  in  W: register-file read data.
- `imm16`  in  16: instruction immediate.
- `alu_src`  in  1: 1 selects the extended immediate for B; 0 selects forwarded rt.
- `imm_zext`  in  1: 1 zero-extends `imm16`; 0 sign-extends it.
- `alu_ctrl_in`  in  4: ALU code, passed through unchanged (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR).
- `dest_in`  in  RA: destination register.
- `reg_write_in`, `mem_read_in`, `mem_write_in`  in  1 each: control flags.
- `ex_result`  in  W: current ALU output, i.e. the result for the instruction held here.
- `mem_fwd_en`  in  1, `mem_fwd_addr`  in  RA, `mem_fwd_data`  in  W: MEM-stage write-back forward.
- `wb_fwd_en`  in  1, `wb_fwd_addr`  in  RA, `wb_fwd_data`  in  W: WB-stage forward.
- `flush`  in  1: squash the held instruction and the incoming one.
- `out_valid`  out  1: held instruction is valid.
- `out_ready`  in  1: downstream advances this cycle.
- `op_a`, `op_b`  out  W: ALU operands.
- `alu_ctrl`  out  4: ALU control code.
- `store_data`  out  W: forwarded rt value, used by stores.
- `dest`  out  RA: destination register.
- `reg_write`, `mem_read`, `mem_write`  out  1 each: registered copies of the control flags.

## Operation
- Advance condition: `adv = !out_valid || out_ready`.
- Load-use hazard: `hz = in_valid && out_valid && mem_read && dest != 0 && (dest == rs_addr || (dest == rt_addr && (!alu_src || mem_write_in)))`.
- `in_ready = adv && !hz && !flush`.
- Forwarding for each source `s` in {rs, rt}, first match wins:
  - `s == 0` gives 0.
  - `out_valid && reg_write && !mem_read && dest == s` gives `ex_result`.
  - `mem_fwd_en && mem_fwd_addr == s` gives `mem_fwd_data`.
  - `wb_fwd_en && wb_fwd_addr == s` gives `wb_fwd_data`.
  - Otherwise the register-file data.
- Operand mapping: `op_a` is forwarded rs. `op_b` is the extended immediate when `alu_src`, otherwise forwarded rt. `store_data` is always forwarded rt.
- Extension:
  - Sign: `{{16{imm16[15]}}, imm16}`.
  - Zero: `{16'b0, imm16}`.
- Register update, in priority order:
  1. `reset`: all output registers are 0.
  2. `flush`: `out_valid` and all control flags are 0; data registers hold.
  3. `adv && in_valid && !hz`: capture the instruction; `out_valid` is 1.
  4. `adv && (hz || !in_valid)`: bubble; `out_valid`, `reg_write`, `mem_read` and `mem_write` are 0.
  5. Otherwise hold.
- A bubble or invalid entry never asserts `reg_write`, `mem_read` or `mem_write`.

## Timing
- Latency: one cycle from accepted input to `op_a`/`op_b`/`alu_ctrl`.
- Throughput: one instruction per cycle without hazards.
- A load-use hazard costs exactly one bubble cycle. In the next cycle `hz` is false because the held instruction is the bubble, and the consumer is accepted with the load result on the MEM forward.
- When `!out_ready`, every output holds bit-stable and `in_ready` is 0.
- `flush` coinciding with `hz` or `!out_ready`: flush wins, and `out_valid` is 0 next cycle.
- `reset` mid-stall clears the stage and `out_valid` is 0 the next cycle. `in_ready` may be 1 during `reset`, but no capture occurs.

## Structure
- A shared package `mips_pkg` holds the ALU code constants (`ALU_AND`=0, `ALU_OR`=1, `ALU_ADD`=2, `ALU_SUB`=6, `ALU_SLT`=7, `ALU_NOR`=12) and the width constants.
- Sub-module `operand_fwd_mux` resolves one source and is instantiated twice (rs, rt). It is purely combinational; all state lives in the top.

## Test plan
- Reset, then `in_valid` with `rs_data`=5, `rt_data`=3, `alu_src`=0, `alu_ctrl_in`=6 -> next cycle `op_a`=5, `op_b`=3, `alu_ctrl`=6, `out_valid`=1.
- `imm16`=16'hFFFE: with `imm_zext`=0 -> `op_b`=32'hFFFFFFFE; with `imm_zext`=1 -> `op_b`=32'h0000FFFE.
- Held add with `dest`=8 and `ex_result`=42, next instruction reads rs=8 while MEM and WB also match 8 -> `op_a`=42 (EX priority). With rs=0 under any forward -> `op_a`=0.
- Held `lw` with `dest`=9, next instruction reads rt=9 (R-type) -> `in_ready`=0 for one cycle, a bubble is inserted, then capture with `mem_fwd_data`=77 -> `op_b`=77.
- `out_ready`=0 for 3 cycles -> outputs are unchanged and `in_ready`=0; releasing it accepts the pending instruction.
- `flush` asserted together with a hazard and `out_ready`=0 -> next cycle `out_valid`=0 and all control flags are 0.
